// File: rtl/echo_processor_if.sv
// Sample stream and echo settings between the codec path, the echo control block and the echo engine.
interface echo_processor_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] sample_in;
    logic                     sample_valid;
    logic [31:0]              delay_time;
    logic [31:0]              delay_volume;
    logic                     disabled;
    logic signed [DATA_W-1:0] sample_out;
    logic                     out_valid;
    logic                     overrun;

    modport master (
        output sample_in, sample_valid, delay_time, delay_volume, disabled,
        input  sample_out, out_valid, overrun
    );

    modport slave (
        input  sample_in, sample_valid, delay_time, delay_volume, disabled,
        output sample_out, out_valid, overrun
    );
endinterface

// File: rtl/echo_processor.sv
// Echo/delay engine: circular delay RAM with feedback, volume-scaled echo mixed into the output with saturation.
module echo_processor #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input logic             CLK,
    input logic             RESET_N,
    echo_processor_if.slave echo_if
);
    localparam logic [31:0]     MAX_DLY  = 32'((64'd1 << ADDR_W) - 64'd1);
    localparam logic [ADDR_W:0] FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_MIX,
        S_WRITE
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]          fill_q, fill_d;
    logic signed [DATA_W-1:0] smp_q, smp_d;
    logic                     bypass_q, bypass_d;
    logic [ADDR_W-1:0]        dly_q, dly_d;
    logic [2:0]               vol_q, vol_d;
    logic signed [DATA_W-1:0] sample_out_q, sample_out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     overrun_q, overrun_d;

    logic signed [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
    logic signed [DATA_W-1:0] rd_data_q;
    logic [ADDR_W-1:0]        rd_addr;
    logic                     ram_we;

    logic [ADDR_W-1:0]        dly_clamp;
    logic [2:0]               vol_clamp;
    logic [2:0]               shamt;
    logic signed [DATA_W-1:0] echo;
    logic signed [DATA_W:0]   mix_wide;
    logic signed [DATA_W-1:0] mix_sat;

    always_comb begin
        dly_clamp = echo_if.delay_time[ADDR_W-1:0];
        if (echo_if.delay_time == 32'd0) begin
            dly_clamp = {{(ADDR_W-1){1'b0}}, 1'b1};
        end else if (echo_if.delay_time > MAX_DLY) begin
            dly_clamp = '1;
        end

        vol_clamp = echo_if.delay_volume[2:0];
        if (echo_if.delay_volume < 32'd1) begin
            vol_clamp = 3'd1;
        end else if (echo_if.delay_volume > 32'd6) begin
            vol_clamp = 3'd6;
        end
    end

    assign rd_addr = wr_ptr_q - dly_q;

    // Echo is muted until D samples have been written since reset, so stale RAM is never heard.
    always_comb begin
        shamt = 3'd7 - vol_q;
        echo  = '0;
        if (fill_q >= {1'b0, dly_q}) begin
            echo = rd_data_q >>> shamt;
        end
        mix_wide = {smp_q[DATA_W-1], smp_q} + {echo[DATA_W-1], echo};
        mix_sat  = mix_wide[DATA_W-1:0];
        if (mix_wide[DATA_W] != mix_wide[DATA_W-1]) begin
            mix_sat = mix_wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        smp_d        = smp_q;
        bypass_d     = bypass_q;
        dly_d        = dly_q;
        vol_d        = vol_q;
        sample_out_d = sample_out_q;
        out_valid_d  = 1'b0;
        overrun_d    = 1'b0;
        ram_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (echo_if.sample_valid) begin
                    smp_d    = echo_if.sample_in;
                    bypass_d = echo_if.disabled;
                    dly_d    = dly_clamp;
                    vol_d    = vol_clamp;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                state_d = S_MIX;
            end
            S_MIX: begin
                sample_out_d = bypass_q ? smp_q : mix_sat;
                out_valid_d  = 1'b1;
                state_d      = S_WRITE;
            end
            S_WRITE: begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + (ADDR_W + 1)'(1);
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q != S_IDLE) begin
            overrun_d = echo_if.sample_valid;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            smp_q        <= '0;
            bypass_q     <= 1'b0;
            dly_q        <= '0;
            vol_q        <= '0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            smp_q        <= smp_d;
            bypass_q     <= bypass_d;
            dly_q        <= dly_d;
            vol_q        <= vol_d;
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    // The registered output doubles as the store value; reset forces IDLE so a pending write never lands.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            mem[wr_ptr_q] <= sample_out_q;
        end
        if (state_q == S_READ) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign echo_if.sample_out = sample_out_q;
    assign echo_if.out_valid  = out_valid_q;
    assign echo_if.overrun    = overrun_q;
endmodule

// File: tb/tb_echo_processor.sv
// Directed bench for echo_processor: echo timing, feedback, saturation, bypass, clamps, reset abort, overrun, pointer wrap.
module tb_echo_processor;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   ov_cnt;
    int   vld_cnt;

    always #5 clk = ~clk;

    echo_processor_if #(.DATA_W(16)) m_if ();
    echo_processor_if #(.DATA_W(16)) s_if ();

    echo_processor #(.ADDR_W(16), .DATA_W(16)) u_dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .echo_if (m_if)
    );

    // Small-depth copy (depth 16) so pointer wrap and the depth-1 delay clamp are reachable quickly.
    echo_processor #(.ADDR_W(4), .DATA_W(16)) u_small (
        .CLK     (clk),
        .RESET_N (rst_n),
        .echo_if (s_if)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int dt, input int vol, input logic dis);
        m_if.delay_time   = 32'(dt);
        m_if.delay_volume = 32'(vol);
        m_if.disabled     = dis;
    endtask

    task automatic send(input int smp, input int exp, input string tag);
        @(negedge clk);
        m_if.sample_in    = 16'(smp);
        m_if.sample_valid = 1'b1;
        @(negedge clk);
        m_if.sample_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, 32'(m_if.out_valid), 0);
        @(negedge clk);
        chk({tag, "_vld"}, 32'(m_if.out_valid), 1);
        chk(tag, 32'(m_if.sample_out), exp);
    endtask

    task automatic send_s(input int smp, input int exp, input string tag);
        @(negedge clk);
        s_if.sample_in    = 16'(smp);
        s_if.sample_valid = 1'b1;
        @(negedge clk);
        s_if.sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_vld"}, 32'(s_if.out_valid), 1);
        chk(tag, 32'(s_if.sample_out), exp);
    endtask

    initial begin
        int exp_echo [13] = '{16000, 0, 0, 0, 8000, 0, 0, 0, 4000, 0, 0, 0, 2000};

        m_if.sample_in    = '0;
        m_if.sample_valid = 1'b0;
        cfg(4, 6, 1'b0);
        s_if.sample_in    = '0;
        s_if.sample_valid = 1'b0;
        s_if.delay_time   = 32'd100000;
        s_if.delay_volume = 32'd6;
        s_if.disabled     = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_out", 32'(m_if.sample_out), 0);
        chk("rst_vld", 32'(m_if.out_valid), 0);
        chk("rst_ovr", 32'(m_if.overrun), 0);
        rst_n = 1'b1;

        // Impulse with D=4, V=6: each echo is half the previous one.
        for (int i = 0; i < 13; i++) begin
            send((i == 0) ? 16000 : 0, exp_echo[i], $sformatf("echo%0d", i));
        end

        // Bypass: output and stored value are the raw input.
        cfg(4, 6, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send((i == 0) ? 16000 : 0, (i == 0) ? 16000 : 0, $sformatf("byp%0d", i));
        end

        // Re-enabled with D=8: the 16000 stored while bypassed is heard once as 8000.
        cfg(8, 6, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send(0, (i == 0) ? 8000 : 0, $sformatf("reen%0d", i));
        end

        cfg(1, 6, 1'b0);
        send(30000, 30000, "satp0");
        send(30000, 32767, "satp1");
        send(30000, 32767, "satp2");
        send(-30000, -13617, "satn0");
        send(-30000, -32768, "satn1");
        send(-30000, -32768, "satn2");

        cfg(0, 6, 1'b0);
        send(1000, -15384, "dly0_a");
        send(0, -7692, "dly0_b");
        cfg(0, 9, 1'b0);
        send(0, -3846, "vol9");
        cfg(25, 0, 1'b0);
        send(0, 250, "vol0");
        cfg(100000, 6, 1'b0);
        send(1234, 1234, "dlymax");

        // Depth-16 copy, delay clamped to 15: echoes at samples 15 and 30 straddle the pointer wrap.
        for (int i = 0; i < 31; i++) begin
            send_s((i == 0) ? 16000 : 0,
                   (i == 0) ? 16000 : (i == 15) ? 8000 : (i == 30) ? 4000 : 0,
                   $sformatf("wrap%0d", i));
        end

        // Reset while in MIX.
        @(negedge clk);
        m_if.sample_in    = 16'sd500;
        m_if.sample_valid = 1'b1;
        @(negedge clk);
        m_if.sample_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmix_out", 32'(m_if.sample_out), 0);
        chk("rstmix_vld", 32'(m_if.out_valid), 0);
        @(negedge clk);
        chk("rstmix_vld2", 32'(m_if.out_valid), 0);
        rst_n = 1'b1;

        // Read address lands on old RAM data (16000); fill guard must mute it.
        cfg(65523, 6, 1'b0);
        send(0, 0, "stale");
        cfg(4, 6, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send(1000, 1000, $sformatf("post%0d", i));
        end
        send(0, 500, "post_echo");

        // Two back-to-back strobes: the second is dropped and flagged.
        ov_cnt  = 0;
        vld_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            m_if.sample_valid = (i < 2);
            m_if.sample_in    = (i == 0) ? 16'sd700 : -16'sd5;
            if (m_if.overrun) ov_cnt++;
            if (m_if.out_valid) begin
                vld_cnt++;
                chk("ovr_out", 32'(m_if.sample_out), 1200);
            end
        end
        chk("ovr_pulses", ov_cnt, 1);
        chk("ovr_valids", vld_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
